demux18_8b_buf: RTL and testbench

//  1-to-8 demultiplexer for 8-bit words; the distribution counterpart of mux81_8b.

---
 rtl/demux18_8b_buf_pkg.sv | 25 ++
 rtl/demux18_8b_buf_slot.sv | 38 +++
 rtl/demux18_8b_buf.sv | 60 ++++++
 tb/tb_demux18_8b_buf.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux18_8b_buf_pkg.sv
// Shared widths, types and the select decoder for the 1-to-8 word demultiplexer.
// Imported by the channel slot and the top level.
package demux18_8b_buf_pkg;

    localparam int WIDTH = 8;
    localparam int CH    = 8;
    localparam int SEL_W = 3;
    localparam int CW    = 16;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [CH-1:0]    ch_mask_t;

    // One-hot target mask; broadcast targets every channel.
    function automatic ch_mask_t sel_decode(input logic [SEL_W-1:0] sel, input logic bcast);
        ch_mask_t mask;
        mask = '0;
        if (bcast) begin
            mask = '1;
        end else begin
            mask[sel] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/demux18_8b_buf_slot.sv
// One-entry holding register for a single output channel with a valid/ready drain side.
// The slot reports itself free when empty or when its held word leaves this cycle.
module demux18_8b_buf_slot
    import demux18_8b_buf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t din,
    input  logic  out_ready,
    output logic  valid,
    output word_t dout,
    output logic  free
);

    logic  r_valid;
    word_t r_data;

    assign free  = ~r_valid | out_ready;
    assign valid = r_valid;
    assign dout  = r_data;

    // NOTE: state registers use non-blocking assignments so every slot samples the same pre-edge values.
    // NOTE: the data register is reset too, because out_data must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= din;
        end else if (out_ready) begin
            // Data is left in place after a drain; only the flag clears.
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux18_8b_buf.sv
// 1-to-8 demultiplexer for 8-bit words with per-channel one-entry buffers and broadcast.
// Holds the select decode, broadcast readiness, input handshake and accepted-word counter.
module demux18_8b_buf
    import demux18_8b_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CH*WIDTH-1:0]   out_data,
    output logic [CH-1:0]         out_valid,
    input  logic [CH-1:0]         out_ready,
    output logic [CW-1:0]         acc_cnt
);

    ch_mask_t        w_free;
    ch_mask_t        w_load;
    logic            w_accept;
    logic [CW-1:0]   r_acc_cnt;

    // Broadcast is all-or-nothing: every slot must be able to take the word this cycle.
    // NOTE: in_ready gets a default first so this combinational block cannot infer a latch.
    always_comb begin
        in_ready = 1'b0;
        if (en && !rst) begin
            in_ready = in_bcast ? (&w_free) : w_free[in_sel];
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? sel_decode(in_sel, in_bcast) : '0;

    for (genvar i = 0; i < CH; i++) begin : g_slot
        demux18_8b_buf_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load[i]),
            .din       (in_data),
            .out_ready (out_ready[i]),
            .valid     (out_valid[i]),
            .dout      (out_data[i*WIDTH +: WIDTH]),
            .free      (w_free[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CW'(1);
        end
    end

    assign acc_cnt = r_acc_cnt;

endmodule

// File: tb/tb_demux18_8b_buf.sv
// Scoreboard bench for demux18_8b_buf: per-channel expected-word queues, a monitor
// comparing every cycle at the falling edge, directed scenarios plus randomized traffic.
module tb_demux18_8b_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [7:0]  in_data = 8'hFF;
    logic [2:0]  in_sel = 3'd0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready = 8'hFF;
    logic [15:0] acc_cnt;

    int checks = 0;
    int failures = 0;

    typedef logic [7:0] word_q_t [$];
    word_q_t     exp_q [8];
    logic [7:0]  exp_last [8];
    logic [15:0] exp_acc = 16'd0;
    logic        model_accept = 1'b0;

    logic [7:0]  m_occ;
    logic [7:0]  m_free;
    logic        m_rdy;
    logic [63:0] m_data;

    demux18_8b_buf dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_last[i] = 8'h00;
    end

    // Monitor: the held word of each channel is the front of its queue; an empty queue
    // means the channel shows its last loaded word with valid low.
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) begin
            m_occ[i]        = (exp_q[i].size() != 0);
            m_free[i]       = !m_occ[i] || out_ready[i];
            m_data[i*8 +: 8] = m_occ[i] ? exp_q[i][0] : exp_last[i];
        end
        m_rdy = en && !rst && (in_bcast ? (&m_free) : m_free[in_sel]);
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("out_valid", 64'(out_valid), 64'(m_occ));
        check("out_data", out_data, m_data);
        check("acc_cnt", 64'(acc_cnt), 64'(exp_acc));
        model_accept = in_valid && m_rdy;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                exp_q[i].delete();
                exp_last[i] = 8'h00;
            end
            exp_acc = 16'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (m_occ[i] && out_ready[i]) void'(exp_q[i].pop_front());
            end
        end
    end

    // Push side: an accepted word is expected on every targeted channel next cycle.
    always @(negedge clk) begin
        #1;
        if (model_accept) begin
            for (int i = 0; i < 8; i++) begin
                if (in_bcast || in_sel == 3'(i)) begin
                    exp_q[i].push_back(in_data);
                    exp_last[i] = in_data;
                end
            end
            exp_acc = exp_acc + 16'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic b,
                        input bit rnd, output bit ok);
        in_data  = d;
        in_sel   = s;
        in_bcast = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (rnd) begin
                out_ready = 8'($urandom);
                en        = ($urandom_range(0, 7) != 0);
            end
            @(negedge clk);
            #2;
            ok = model_accept;
            step();
        end
        in_valid = 1'b0;
        in_bcast = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word %h sel %0d bcast %0d not accepted in 200 cycles", d, s, b);
        end
    endtask

    initial begin
        bit ok;

        // Reset held two cycles with a pending word.
        step();
        step();
        sample();
        check("t1_in_ready", 64'(in_ready), 64'd0);
        check("t1_out_valid", 64'(out_valid), 64'h00);
        check("t1_out_data", out_data, 64'd0);
        check("t1_acc_cnt", 64'(acc_cnt), 64'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;

        // Single route to channel 5.
        out_ready = 8'hFF;
        send(8'hA5, 3'd5, 1'b0, 1'b0, ok);
        sample();
        check("t2_out_valid", 64'(out_valid), 64'h20);
        check("t2_ch5_data", 64'(out_data[47:40]), 64'hA5);
        check("t2_acc_cnt", 64'(acc_cnt), 64'd1);
        step();
        sample();
        check("t2_drained", 64'(out_valid), 64'h00);

        // Backpressure on channel 2, then same-cycle drain and reload.
        step();
        out_ready = 8'hFB;
        send(8'h11, 3'd2, 1'b0, 1'b0, ok);
        in_data = 8'h22;
        in_sel = 3'd2;
        in_valid = 1'b1;
        repeat (3) step();
        sample();
        check("t3_stall_ready", 64'(in_ready), 64'd0);
        check("t3_hold_data", 64'(out_data[23:16]), 64'h11);
        step();
        out_ready = 8'hFF;
        sample();
        check("t3_reload_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        out_ready = 8'h00;
        sample();
        check("t3_new_data", 64'(out_data[23:16]), 64'h22);
        check("t3_still_valid", 64'(out_valid[2]), 64'd1);
        step();
        out_ready = 8'hFF;
        step();

        // Broadcast blocked by a stalled channel 3, then released.
        out_ready = 8'hF7;
        send(8'h77, 3'd3, 1'b0, 1'b0, ok);
        in_data = 8'h3C;
        in_sel = 3'd6;
        in_bcast = 1'b1;
        in_valid = 1'b1;
        repeat (2) step();
        sample();
        check("t4_bcast_blocked", 64'(in_ready), 64'd0);
        check("t4_no_partial", 64'(out_valid), 64'h08);
        step();
        out_ready = 8'hFF;
        sample();
        check("t4_bcast_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        sample();
        check("t4_all_valid", 64'(out_valid), 64'hFF);
        check("t4_all_data", out_data, {8{8'h3C}});

        // Enable low: no accepts, held words drain, counter frozen.
        step();
        out_ready = 8'h00;
        send(8'h5A, 3'd0, 1'b0, 1'b0, ok);
        send(8'h6B, 3'd7, 1'b0, 1'b0, ok);
        en = 1'b0;
        in_data = 8'h99;
        in_sel = 3'd0;
        in_valid = 1'b1;
        out_ready = 8'hFF;
        sample();
        check("t5_en_ready", 64'(in_ready), 64'd0);
        step();
        sample();
        check("t5_drained", 64'(out_valid), 64'h00);
        check("t5_acc_frozen", 64'(acc_cnt), 64'd7);
        step();
        in_valid = 1'b0;
        en = 1'b1;

        // Randomized traffic with random stalls, enable and broadcasts.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                out_ready = 8'($urandom);
                en = ($urandom_range(0, 3) != 0);
                step();
            end
            send(8'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0), 1'b1, ok);
        end
        en = 1'b1;
        out_ready = 8'hFF;
        step();

        // Drive the counter to its last value, then one more accept wraps it.
        in_bcast = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 70000 && exp_acc != 16'hFFFF; k++) begin
            in_data = 8'($urandom);
            in_sel = 3'($urandom);
            step();
        end
        in_valid = 1'b0;
        sample();
        check("t6_acc_max", 64'(acc_cnt), 64'hFFFF);
        step();
        send(8'hC3, 3'd4, 1'b0, 1'b0, ok);
        sample();
        check("t6_acc_wrap", 64'(acc_cnt), 64'd0);

        // Reset while three channels hold words.
        step();
        out_ready = 8'h00;
        send(8'h01, 3'd1, 1'b0, 1'b0, ok);
        send(8'h04, 3'd4, 1'b0, 1'b0, ok);
        send(8'h06, 3'd6, 1'b0, 1'b0, ok);
        sample();
        check("t6_three_held", 64'(out_valid), 64'h52);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check("t6_reset_valid", 64'(out_valid), 64'h00);
        check("t6_reset_acc", 64'(acc_cnt), 64'd0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
